// File: rtl/mux_rr_stream.sv
// N-input registered stream multiplexer: one requesting channel per cycle is
// granted (round-robin or lowest-index priority) and loaded into a single output register.
module mux_rr_stream #(
  parameter int BUS_SIZE = 32,
  parameter int NUM_IN   = 4,
  localparam int SEL_W   = $clog2(NUM_IN)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_IN*BUS_SIZE-1:0] in_data,
  input  logic [NUM_IN-1:0]          in_valid,
  output logic [NUM_IN-1:0]          in_ready,
  input  logic                       mode,
  output logic [BUS_SIZE-1:0]        out_data,
  output logic [SEL_W-1:0]           out_sel,
  output logic                       out_valid,
  input  logic                       out_ready
);

  // Handshake: a word moves on a rising edge when valid and ready are both high;
  // valid must not wait on ready, and in_ready is one-hot on the granted channel only.

  logic [BUS_SIZE-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0]    out_sel_q, out_sel_d;
  logic                out_valid_q, out_valid_d;
  logic [SEL_W-1:0]    last_grant_q, last_grant_d;

  logic                load_en;
  logic                grant_found;
  logic [SEL_W-1:0]    grant_idx;
  logic [SEL_W-1:0]    rr_idx;

  // The output register may be refilled whenever it is empty or being drained.
  assign load_en = !out_valid_q || out_ready;

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    rr_idx      = last_grant_q;
    if (mode) begin
      for (int i = NUM_IN - 1; i >= 0; i--) begin
        if (in_valid[i]) begin
          grant_found = 1'b1;
          grant_idx   = SEL_W'(i);
        end
      end
    end else begin
      // Explicit wrap keeps the pointer in range for non-power-of-two NUM_IN.
      for (int k = 0; k < NUM_IN; k++) begin
        rr_idx = (rr_idx == SEL_W'(NUM_IN - 1)) ? '0 : rr_idx + SEL_W'(1);
        if (!grant_found && in_valid[rr_idx]) begin
          grant_found = 1'b1;
          grant_idx   = rr_idx;
        end
      end
    end
  end

  always_comb begin
    out_data_d   = out_data_q;
    out_sel_d    = out_sel_q;
    out_valid_d  = out_valid_q;
    last_grant_d = last_grant_q;
    in_ready     = '0;
    if (load_en && grant_found) begin
      in_ready[grant_idx] = rst_n;
      out_data_d   = in_data[int'(grant_idx)*BUS_SIZE +: BUS_SIZE];
      out_sel_d    = grant_idx;
      out_valid_d  = 1'b1;
      last_grant_d = grant_idx;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q   <= '0;
      out_sel_q    <= '0;
      out_valid_q  <= 1'b0;
      last_grant_q <= SEL_W'(NUM_IN - 1);
    end else begin
      out_data_q   <= out_data_d;
      out_sel_q    <= out_sel_d;
      out_valid_q  <= out_valid_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_rr_stream.sv
// Bench for mux_rr_stream: a 4-input and a 3-input instance driven by directed
// scenarios and random traffic, checked against a cycle-level reference model.
module tb_mux_rr_stream;
  localparam int W = 32;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // 4-input instance
  logic [4*W-1:0] in_data4 = '0;
  logic [3:0]     in_valid4 = '0;
  logic [3:0]     in_ready4;
  logic           mode4 = 1'b0;
  logic [W-1:0]   out_data4;
  logic [1:0]     out_sel4;
  logic           out_valid4;
  logic           out_ready4 = 1'b1;

  // 3-input instance
  logic [3*W-1:0] in_data3 = '0;
  logic [2:0]     in_valid3 = '0;
  logic [2:0]     in_ready3;
  logic           mode3 = 1'b0;
  logic [W-1:0]   out_data3;
  logic [1:0]     out_sel3;
  logic           out_valid3;
  logic           out_ready3 = 1'b1;

  mux_rr_stream #(.BUS_SIZE(W), .NUM_IN(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data4), .in_valid(in_valid4),
    .in_ready(in_ready4), .mode(mode4), .out_data(out_data4), .out_sel(out_sel4),
    .out_valid(out_valid4), .out_ready(out_ready4)
  );

  mux_rr_stream #(.BUS_SIZE(W), .NUM_IN(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data3), .in_valid(in_valid3),
    .in_ready(in_ready3), .mode(mode3), .out_data(out_data3), .out_sel(out_sel3),
    .out_valid(out_valid3), .out_ready(out_ready3)
  );

  int n_checks = 0;
  int n_errors = 0;

  // scoreboard: words accepted at the inputs, in order, awaiting the output drain
  logic [W-1:0] exp_q4[$];
  logic [W-1:0] exp_q3[$];

  // reference model state, index 0 = 4-input, 1 = 3-input
  logic         m_valid[2];
  logic [W-1:0] m_data[2];
  int           m_sel[2];
  int           m_last[2];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Grant from the arbitration rules: priority scan or rotating scan from last+1.
  function automatic int pick(input int n, input int last, input logic md, input logic [3:0] v);
    int g;
    g = -1;
    if (md) begin
      for (int i = n - 1; i >= 0; i--) if (v[i]) g = i;
    end else begin
      for (int k = n; k >= 1; k--) if (v[(last + k) % n]) g = (last + k) % n;
    end
    return g;
  endfunction

  task automatic model_reset();
    for (int j = 0; j < 2; j++) begin
      m_valid[j] = 1'b0;
      m_data[j]  = '0;
      m_sel[j]   = 0;
    end
    m_last[0] = 3;
    m_last[1] = 2;
    exp_q4.delete();
    exp_q3.delete();
  endtask

  task automatic model_cycle(input int j, input int n, input string p,
                             input logic [3:0] v, input logic [4*W-1:0] d,
                             input logic md, input logic ordy, input logic [3:0] g_rdy,
                             input logic g_val, input logic [W-1:0] g_data, input int g_sel);
    logic         load;
    int           g;
    logic [W-1:0] w;
    check({p, "_out_valid"}, 64'(g_val), 64'(m_valid[j]));
    check({p, "_out_data"}, 64'(g_data), 64'(m_data[j]));
    check({p, "_out_sel"}, 64'(g_sel), 64'(m_sel[j]));
    load = !m_valid[j] || ordy;
    g = load ? pick(n, m_last[j], md, v) : -1;
    check({p, "_in_ready"}, 64'(g_rdy), (g >= 0) ? (64'd1 << g) : 64'd0);
    if (g_val && ordy) begin
      if (j == 0) begin
        if (exp_q4.size() == 0) check({p, "_sb_extra_word"}, 64'd1, 64'd0);
        else check({p, "_sb_data"}, 64'(g_data), 64'(exp_q4.pop_front()));
      end else begin
        if (exp_q3.size() == 0) check({p, "_sb_extra_word"}, 64'd1, 64'd0);
        else check({p, "_sb_data"}, 64'(g_data), 64'(exp_q3.pop_front()));
      end
    end
    if (g >= 0) begin
      w = d[g*W +: W];
      if (j == 0) exp_q4.push_back(w);
      else exp_q3.push_back(w);
      m_valid[j] = 1'b1;
      m_data[j]  = w;
      m_sel[j]   = g;
      m_last[j]  = g;
    end else if (m_valid[j] && ordy) begin
      m_valid[j] = 1'b0;
    end
  endtask

  // Check both instances mid-cycle, then advance to just after the next edge.
  task automatic cycle();
    @(negedge clk);
    model_cycle(0, 4, "d4", in_valid4, in_data4, mode4, out_ready4, in_ready4,
                out_valid4, out_data4, int'(out_sel4));
    model_cycle(1, 3, "d3", {1'b0, in_valid3}, {{W{1'b0}}, in_data3}, mode3, out_ready3,
                {1'b0, in_ready3}, out_valid3, out_data3, int'(out_sel3));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_valid4", 64'(out_valid4), 64'd0);
    check("rst_data4", 64'(out_data4), 64'd0);
    check("rst_sel4", 64'(out_sel4), 64'd0);
    check("rst_ready4", 64'(in_ready4), 64'd0);
    check("rst_valid3", 64'(out_valid3), 64'd0);
    check("rst_ready3", 64'(in_ready3), 64'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic set_ch4(input int c, input logic [W-1:0] v);
    in_data4[c*W +: W] = v;
  endtask

  initial begin
    // reset with every input requesting: nothing may be granted
    in_valid4 = 4'hF;
    in_valid3 = 3'h7;
    do_reset();

    // idle after reset
    in_valid4 = '0;
    in_valid3 = '0;
    repeat (2) cycle();

    // round-robin, all valid, one word per cycle
    for (int c = 0; c < 4; c++) set_ch4(c, W'(32'hA0 + c));
    in_valid4 = 4'hF;
    for (int i = 0; i < 8; i++) begin
      cycle();
      check("rr_seq_sel", 64'(out_sel4), 64'(i % 4));
      check("rr_seq_data", 64'(out_data4), 64'(32'hA0 + i % 4));
      check("rr_seq_valid", 64'(out_valid4), 64'd1);
    end

    // asynchronous reset while a word is held
    #2;
    do_reset();

    // fixed priority
    mode4 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      check("fp_sel0", 64'(out_sel4), 64'd0);
    end
    in_valid4 = 4'hE;
    for (int i = 0; i < 4; i++) begin
      cycle();
      check("fp_sel1", 64'(out_sel4), 64'd1);
    end

    // backpressure holds the word; release grants the next channel
    mode4 = 1'b0;
    set_ch4(2, 32'hDEADBEEF);
    in_valid4 = 4'h4;
    cycle();
    check("bp_load_sel", 64'(out_sel4), 64'd2);
    in_valid4  = 4'hF;
    out_ready4 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("bp_hold_data", 64'(out_data4), 64'hDEADBEEF);
      check("bp_hold_sel", 64'(out_sel4), 64'd2);
      check("bp_in_ready", 64'(in_ready4), 64'd0);
    end
    out_ready4 = 1'b1;
    cycle();
    check("bp_release_sel", 64'(out_sel4), 64'd3);

    // mode switch keeps the rotation anchored at the latest winner
    in_valid4 = 4'h2;
    cycle();
    check("ms_rr_sel", 64'(out_sel4), 64'd1);
    mode4 = 1'b1;
    in_valid4 = 4'hF;
    cycle();
    check("ms_fp_sel", 64'(out_sel4), 64'd0);
    mode4 = 1'b0;
    cycle();
    check("ms_back_sel", 64'(out_sel4), 64'd1);

    // three channels: wrap from 2 back to 0
    in_valid4 = '0;
    for (int c = 0; c < 3; c++) in_data3[c*W +: W] = W'(32'hC0 + c);
    in_valid3 = 3'b101;
    for (int i = 0; i < 6; i++) begin
      cycle();
      check("wrap3_sel", 64'(out_sel3), (i % 2 == 0) ? 64'd0 : 64'd2);
    end

    // random traffic on both instances
    for (int i = 0; i < 600; i++) begin
      for (int c = 0; c < 4; c++) in_data4[c*W +: W] = $urandom;
      for (int c = 0; c < 3; c++) in_data3[c*W +: W] = $urandom;
      in_valid4  = 4'($urandom_range(0, 15));
      in_valid3  = 3'($urandom_range(0, 7));
      mode4      = ($urandom_range(0, 4) == 0);
      mode3      = ($urandom_range(0, 4) == 0);
      out_ready4 = ($urandom_range(0, 3) != 0);
      out_ready3 = ($urandom_range(0, 3) != 0);
      if (i == 300) begin
        #2;
        do_reset();
      end else begin
        cycle();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
